// File: rtl/order_queue_flush_pkg.sv
// Shared sizing constants for the in-order tag queue and the blocks that
// size their tags from the same source (ROB, dispatch).
package order_queue_flush_pkg;

  // Ceiling log2; used at elaboration time to derive pointer/count widths.
  function automatic int log2_c(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int OQ_WIDTH        = 5;
  localparam int OQ_DEPTH        = 32;
  localparam int OQ_ADDRESSWIDTH = log2_c(OQ_DEPTH) + 1;
  localparam int OQ_AF_LEVEL     = 28;

endpackage

// File: rtl/order_queue_flush_oq_storage.sv
// Entry storage for the order queue: one synchronous write port, one
// asynchronous read port, deliberately no reset on the array.
module oq_storage
  import order_queue_flush_pkg::*;
#(
  parameter int WIDTH = OQ_WIDTH,
  parameter int DEPTH = OQ_DEPTH,
  parameter int AW    = OQ_ADDRESSWIDTH - 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed entry at the write pointer.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/order_queue_flush.sv
// In-order queue of instruction tags between dispatch and retire.
// First-word-fall-through head, push/pop in the same cycle at any
// occupancy, synchronous flush for mispredict recovery, sticky errors.
// Occupancy comes only from the count register; pointers wrap silently.
module order_queue_flush
  import order_queue_flush_pkg::*;
#(
  parameter int WIDTH        = OQ_WIDTH,
  parameter int DEPTH        = OQ_DEPTH,
  parameter int ADDRESSWIDTH = OQ_ADDRESSWIDTH,
  parameter int AF_LEVEL     = OQ_AF_LEVEL
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        inData,
  input  logic                    new_data,
  input  logic                    out_data,
  input  logic                    flush,
  output logic [WIDTH-1:0]        outData,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [ADDRESSWIDTH-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ADDRESSWIDTH - 1;

  localparam logic [PW-1:0]           PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDRESSWIDTH-1:0] CNT_ONE  = {{(ADDRESSWIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRESSWIDTH-1:0] CNT_FULL = ADDRESSWIDTH'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] CNT_AF   = ADDRESSWIDTH'(AF_LEVEL);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic             wr_en;
  logic [WIDTH-1:0] head_data;

  // Status decodes look only at the count register, never at the requests.
  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_AF);

  // A pop at full frees the slot the same cycle; a pop at empty is rejected
  // even with a push present (no bypass).
  assign pop_ok  = out_data && !empty;
  assign push_ok = new_data && (!full || out_data);
  assign wr_en   = push_ok && !flush;

  oq_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (inData),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  assign outData = empty ? '0 : head_data;

  // Pointer and occupancy update; flush discards any push/pop in its cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (new_data && full && !out_data && !flush) overflow <= 1'b1;
      if (out_data && empty && !flush)             underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_order_queue_flush.sv
// Directed bench for order_queue_flush with default parameters
// (WIDTH=5, DEPTH=32, AF_LEVEL=28).
module tb_order_queue_flush;

  logic       clock;
  logic       reset;
  logic [4:0] inData;
  logic       new_data;
  logic       out_data;
  logic       flush;
  logic [4:0] outData;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [5:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  order_queue_flush dut (
    .clock       (clock),
    .reset       (reset),
    .inData      (inData),
    .new_data    (new_data),
    .out_data    (out_data),
    .flush       (flush),
    .outData     (outData),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    new_data = 1'b0;
    out_data = 1'b0;
    flush    = 1'b0;
    inData   = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Push values 0..n-1 on consecutive edges.
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      new_data = 1'b1;
      inData   = 5'(i);
      step();
    end
    new_data = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (outData !== 5'd0) begin failures++; $display("FAIL reset_outdata got=%0d exp=0", outData); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      new_data = 1'b1;
      inData   = 5'(i);
      step();
      checks++; if (count !== 6'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 28)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i + 1 >= 28)); end
      checks++; if (full !== (i + 1 == 32)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i + 1 == 32)); end
    end
    new_data = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (outData !== 5'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, outData, i); end
      out_data = 1'b1;
      step();
      checks++; if (count !== 6'(31 - i)) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 31 - i); end
    end
    out_data = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (outData !== 5'd0) begin failures++; $display("FAIL drain_outdata got=%0d exp=0", outData); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL drain_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_overflow();
    apply_reset();
    push_n(32);
    new_data = 1'b1;
    inData   = 5'd9;
    out_data = 1'b0;
    step();
    new_data = 1'b0;
    checks++; if (count !== 6'd32) begin failures++; $display("FAIL ovf_count got=%0d exp=32", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (outData !== 5'(i)) begin failures++; $display("FAIL ovf_drain i=%0d got=%0d exp=%0d", i, outData, i); end
      out_data = 1'b1;
      step();
    end
    out_data = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky_pop got=%b exp=1", overflow); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky_flush got=%b exp=1", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL ovf_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_simul_full();
    apply_reset();
    push_n(32);
    for (int k = 0; k < 100; k++) begin
      checks++; if (outData !== ((k < 32) ? 5'(k) : 5'd4)) begin failures++; $display("FAIL sfull_data k=%0d got=%0d exp=%0d", k, outData, (k < 32) ? k : 4); end
      new_data = 1'b1;
      inData   = 5'd4;
      out_data = 1'b1;
      step();
      checks++; if (count !== 6'd32 || full !== 1'b1) begin failures++; $display("FAIL sfull_count k=%0d got=%0d/%b exp=32/1", k, count, full); end
    end
    idle_inputs();
    checks++; if (outData !== 5'd4) begin failures++; $display("FAIL sfull_tail got=%0d exp=4", outData); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL sfull_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_simul_empty();
    apply_reset();
    new_data = 1'b1;
    inData   = 5'd7;
    out_data = 1'b1;
    step();
    idle_inputs();
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL sempty_count got=%0d exp=1", count); end
    checks++; if (outData !== 5'd7) begin failures++; $display("FAIL sempty_data got=%0d exp=7", outData); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL sempty_underflow got=%b exp=1", underflow); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL sempty_empty got=%b exp=0", empty); end
  endtask

  task automatic test_wrap();
    apply_reset();
    push_n(3);
    for (int k = 0; k < 40; k++) begin
      checks++; if (outData !== 5'(k % 32)) begin failures++; $display("FAIL wrap_data k=%0d got=%0d exp=%0d", k, outData, k % 32); end
      new_data = 1'b1;
      inData   = 5'((k + 3) % 32);
      out_data = 1'b1;
      step();
      checks++; if (count !== 6'd3) begin failures++; $display("FAIL wrap_count k=%0d got=%0d exp=3", k, count); end
    end
    idle_inputs();
    checks++; if (outData !== 5'd8) begin failures++; $display("FAIL wrap_tail got=%0d exp=8", outData); end
  endtask

  task automatic test_flush();
    apply_reset();
    push_n(10);
    checks++; if (count !== 6'd10) begin failures++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
    flush    = 1'b1;
    new_data = 1'b1;
    inData   = 5'd5;
    out_data = 1'b1;
    step();
    idle_inputs();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (outData !== 5'd0) begin failures++; $display("FAIL flush_outdata got=%0d exp=0", outData); end
    new_data = 1'b1;
    inData   = 5'd6;
    step();
    idle_inputs();
    checks++; if (outData !== 5'd6) begin failures++; $display("FAIL flush_next_data got=%0d exp=6", outData); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL flush_next_count got=%0d exp=1", count); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL flush_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_data = 1'b1;
    step();
    out_data = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL areset_pre_underflow got=%b exp=1", underflow); end
    push_n(17);
    checks++; if (count !== 6'd17) begin failures++; $display("FAIL areset_pre_count got=%0d exp=17", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL areset_status got=%b%b exp=10", empty, full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL areset_flags got=%b exp=00", {overflow, underflow}); end
    checks++; if (outData !== 5'd0) begin failures++; $display("FAIL areset_outdata got=%0d exp=0", outData); end
    step();
    reset    = 1'b1;
    new_data = 1'b1;
    inData   = 5'd3;
    step();
    idle_inputs();
    checks++; if (outData !== 5'd3 || count !== 6'd1) begin failures++; $display("FAIL areset_release got=%0d/%0d exp=3/1", outData, count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
